// File: rtl/sprite_motion.sv
// sprite_motion: frame-rate sprite mover with keyboard steering, hold-to-accelerate speed ramp
// and selectable playfield edge behaviour (bounce, wrap or stop).
//
// Ports:
//   frame_clk  in   frame tick, all state updates on its rising edge
//   Reset      in   asynchronous, active-high
//   key        in   16-bit keycode: 0x001A up, 0x0016 down, 0x0004 left, 0x0007 right
//   pause      in   freezes all state, forces hit_edge low
//   PosX/PosY  out  sprite centre
//   SizeOut    out  constant sprite half-size
//   dir        out  0=up, 1=down, 2=left, 3=right
//   speed      out  current speed in pixels/frame
//   moving     out  high while in the moving state
//   hit_edge   out  one-frame pulse after an edge contact
module sprite_motion #(
   parameter int          W            = 10,
   parameter int          X_MIN        = 0,
   parameter int          X_MAX        = 639,
   parameter int          Y_MIN        = 0,
   parameter int          Y_MAX        = 479,
   parameter int          X_CENTER     = 320,
   parameter int          Y_CENTER     = 240,
   parameter int          SIZE         = 4,
   parameter int unsigned MAX_SPEED    = 4,
   parameter int unsigned ACCEL_FRAMES = 8,
   parameter int unsigned EDGE_MODE    = 0
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic [15:0]  key,
   input  logic         pause,
   output logic [W-1:0] PosX,
   output logic [W-1:0] PosY,
   output logic [W-1:0] SizeOut,
   output logic [1:0]   dir,
   output logic [3:0]   speed,
   output logic         moving,
   output logic         hit_edge
);

   typedef enum logic [0:0] {StIdle, StMove} state_e;

   localparam logic [1:0] DirUp    = 2'd0;
   localparam logic [1:0] DirDown  = 2'd1;
   localparam logic [1:0] DirLeft  = 2'd2;
   localparam logic [1:0] DirRight = 2'd3;

   // Signed W+2-bit limits so a step below zero compares correctly instead of wrapping.
   localparam logic signed [W+1:0] XLo = (W+2)'(X_MIN + SIZE);
   localparam logic signed [W+1:0] XHi = (W+2)'(X_MAX - SIZE);
   localparam logic signed [W+1:0] YLo = (W+2)'(Y_MIN + SIZE);
   localparam logic signed [W+1:0] YHi = (W+2)'(Y_MAX - SIZE);

   localparam logic [3:0] MaxSpd  = 4'(MAX_SPEED);
   localparam logic [7:0] CntLast = 8'(ACCEL_FRAMES - 1);

   state_e         state_q;
   logic [W-1:0]   pos_x_q, pos_y_q;
   logic [1:0]     dir_q;
   logic [3:0]     speed_q;
   logic [7:0]     cnt_q;
   logic           hit_q;

   // Key decode
   logic           key_valid;
   logic [1:0]     key_dir;
   logic           key_change;

   always_comb begin
      key_valid = 1'b1;
      key_dir   = DirUp;
      case (key)
         16'h001A: key_dir = DirUp;
         16'h0016: key_dir = DirDown;
         16'h0004: key_dir = DirLeft;
         16'h0007: key_dir = DirRight;
         default:  key_valid = 1'b0;
      endcase
   end

   assign key_change = key_valid && (key_dir != dir_q);

   // Next-position datapath on the axis selected by the registered direction.
   // dir[1] selects the X axis, dir[0] selects the increasing direction.
   logic                  axis_x;
   logic signed [W+1:0]   cur, nxt, lo, hi, spd_s;
   logic                  hit_hi, hit_lo, contact;
   logic [W-1:0]          pos_new;

   always_comb begin
      axis_x = dir_q[1];
      spd_s  = (W+2)'(speed_q);
      if (axis_x) begin
         cur = (W+2)'(pos_x_q);
         lo  = XLo;
         hi  = XHi;
      end else begin
         cur = (W+2)'(pos_y_q);
         lo  = YLo;
         hi  = YHi;
      end
      if (dir_q[0]) nxt = cur + spd_s;
      else          nxt = cur - spd_s;
      hit_hi  = (nxt >= hi);
      hit_lo  = (nxt <= lo);
      contact = hit_hi | hit_lo;
      if (!contact) begin
         pos_new = nxt[W-1:0];
      end else if (EDGE_MODE == 1) begin
         // wrap lands on the opposite limit
         pos_new = hit_hi ? lo[W-1:0] : hi[W-1:0];
      end else begin
         pos_new = hit_hi ? hi[W-1:0] : lo[W-1:0];
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         pos_x_q <= W'(X_CENTER);
         pos_y_q <= W'(Y_CENTER);
         dir_q   <= DirUp;
         speed_q <= 4'd1;
         cnt_q   <= 8'd0;
         hit_q   <= 1'b0;
      end else if (pause) begin
         hit_q <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (key_valid) begin
                  dir_q   <= key_dir;
                  speed_q <= 4'd1;
                  cnt_q   <= 8'd0;
                  state_q <= StMove;
               end
            end
            StMove: begin
               // Motion always uses the registered dir/speed; the key only shapes the next frame.
               if (axis_x) pos_x_q <= pos_new;
               else        pos_y_q <= pos_new;

               if (key_change) begin
                  dir_q   <= key_dir;
                  speed_q <= 4'd1;
                  cnt_q   <= 8'd0;
               end else if (key_valid) begin
                  if (cnt_q == CntLast) begin
                     cnt_q <= 8'd0;
                     if (speed_q < MaxSpd) speed_q <= speed_q + 4'd1;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end else begin
                  cnt_q <= 8'd0;
               end

               // Edge handling overrides the key path where they collide.
               if (contact) begin
                  hit_q <= 1'b1;
                  if (EDGE_MODE == 0) begin
                     if (!key_change) dir_q <= dir_q ^ 2'b01;
                  end else if (EDGE_MODE == 2) begin
                     state_q <= StIdle;
                     speed_q <= 4'd1;
                     cnt_q   <= 8'd0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign PosX     = pos_x_q;
   assign PosY     = pos_y_q;
   assign SizeOut  = W'(SIZE);
   assign dir      = dir_q;
   assign speed    = speed_q;
   assign moving   = (state_q == StMove);
   assign hit_edge = hit_q;

endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: drives three sprite_motion instances (bounce, wrap, stop) with the same
// keyboard stimulus and checks every frame against a frame-level reference model through a
// scoreboard queue.
module tb_sprite_motion;

   localparam int XLO = 0 + 4;
   localparam int XHI = 639 - 4;
   localparam int YLO = 0 + 4;
   localparam int YHI = 479 - 4;
   localparam int MAXS = 4;
   localparam int ACC = 8;

   logic        clk;
   logic        Reset;
   logic [15:0] key;
   logic        pause;

   logic [9:0]  posx [3];
   logic [9:0]  posy [3];
   logic [9:0]  sizeo [3];
   logic [1:0]  dr [3];
   logic [3:0]  sp [3];
   logic        mv [3];
   logic        he [3];

   sprite_motion #(.EDGE_MODE(0)) u_bounce (
      .frame_clk(clk), .Reset(Reset), .key(key), .pause(pause),
      .PosX(posx[0]), .PosY(posy[0]), .SizeOut(sizeo[0]), .dir(dr[0]), .speed(sp[0]),
      .moving(mv[0]), .hit_edge(he[0])
   );
   sprite_motion #(.EDGE_MODE(1)) u_wrap (
      .frame_clk(clk), .Reset(Reset), .key(key), .pause(pause),
      .PosX(posx[1]), .PosY(posy[1]), .SizeOut(sizeo[1]), .dir(dr[1]), .speed(sp[1]),
      .moving(mv[1]), .hit_edge(he[1])
   );
   sprite_motion #(.EDGE_MODE(2)) u_stop (
      .frame_clk(clk), .Reset(Reset), .key(key), .pause(pause),
      .PosX(posx[2]), .PosY(posy[2]), .SizeOut(sizeo[2]), .dir(dr[2]), .speed(sp[2]),
      .moving(mv[2]), .hit_edge(he[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state, one slot per edge mode
   int m_px [3];
   int m_py [3];
   int m_dir [3];
   int m_spd [3];
   int m_cnt [3];
   bit m_mv [3];
   bit m_he [3];

   typedef struct packed {
      int inst;
      int px;
      int py;
      int dr;
      int sp;
      bit mv;
      bit he;
   } exp_t;

   exp_t q [$];

   function automatic int key_to_dir(input logic [15:0] k);
      case (k)
         16'h001A: return 0;
         16'h0016: return 1;
         16'h0004: return 2;
         16'h0007: return 3;
         default:  return -1;
      endcase
   endfunction

   function automatic void model_reset(input int m);
      m_px[m] = 320; m_py[m] = 240; m_dir[m] = 0; m_spd[m] = 1; m_cnt[m] = 0;
      m_mv[m] = 1'b0; m_he[m] = 1'b0;
   endfunction

   // One frame of behaviour for edge mode m.
   function automatic void model_step(input int m, input logic [15:0] k, input logic p,
                                      input logic r);
      int kd, cur, nxt, lo, hi, old_dir;
      bit horiz, turned;
      if (r) begin
         model_reset(m);
         return;
      end
      m_he[m] = 1'b0;
      if (p) return;
      kd = key_to_dir(k);
      if (!m_mv[m]) begin
         if (kd >= 0) begin
            m_dir[m] = kd; m_spd[m] = 1; m_cnt[m] = 0; m_mv[m] = 1'b1;
         end
         return;
      end
      old_dir = m_dir[m];
      horiz   = (old_dir >= 2);
      cur     = horiz ? m_px[m] : m_py[m];
      lo      = horiz ? XLO : YLO;
      hi      = horiz ? XHI : YHI;
      nxt     = (old_dir == 1 || old_dir == 3) ? cur + m_spd[m] : cur - m_spd[m];
      turned  = 1'b0;
      if (kd >= 0 && kd != old_dir) begin
         m_dir[m] = kd; m_spd[m] = 1; m_cnt[m] = 0; turned = 1'b1;
      end else if (kd == old_dir) begin
         m_cnt[m]++;
         if (m_cnt[m] == ACC) begin
            m_cnt[m] = 0;
            m_spd[m] = (m_spd[m] + 1 > MAXS) ? MAXS : m_spd[m] + 1;
         end
      end else begin
         m_cnt[m] = 0;
      end
      if (nxt >= hi || nxt <= lo) begin
         m_he[m] = 1'b1;
         if (m == 1) begin
            nxt = (nxt >= hi) ? lo : hi;
         end else begin
            nxt = (nxt >= hi) ? hi : lo;
            if (m == 0 && !turned) begin
               case (old_dir)
                  0: m_dir[m] = 1;
                  1: m_dir[m] = 0;
                  2: m_dir[m] = 3;
                  default: m_dir[m] = 2;
               endcase
            end
            if (m == 2) begin
               m_mv[m] = 1'b0; m_spd[m] = 1; m_cnt[m] = 0;
            end
         end
      end
      if (horiz) m_px[m] = nxt;
      else       m_py[m] = nxt;
   endfunction

   function automatic void push_all();
      for (int m = 0; m < 3; m++) begin
         exp_t e;
         e.inst = m; e.px = m_px[m]; e.py = m_py[m]; e.dr = m_dir[m]; e.sp = m_spd[m];
         e.mv = m_mv[m]; e.he = m_he[m];
         q.push_back(e);
      end
   endfunction

   function automatic void chk(input string nm, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[mode %0d] got %0d expected %0d at %0t", nm, inst, act, exp, $time);
      end
   endfunction

   // One frame: drive inputs mid-frame, then advance the model on the rising edge.
   task automatic tick(input logic [15:0] k, input logic p);
      @(negedge clk);
      key   = k;
      pause = p;
      @(posedge clk);
      for (int m = 0; m < 3; m++) model_step(m, k, p, Reset);
      push_all();
   endtask

   task automatic hold(input logic [15:0] k, input int n);
      for (int i = 0; i < n; i++) tick(k, 1'b0);
   endtask

   // Called right after tick returns: reset lands between edges and must show before the next one.
   task automatic mid_reset();
      #2;
      Reset = 1'b1;
      for (int m = 0; m < 3; m++) model_reset(m);
      q.delete();
      push_all();
      tick(16'h0007, 1'b0);
      #2;
      Reset = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("PosX", e.inst, int'(posx[e.inst]), e.px);
            chk("PosY", e.inst, int'(posy[e.inst]), e.py);
            chk("dir", e.inst, int'(dr[e.inst]), e.dr);
            chk("speed", e.inst, int'(sp[e.inst]), e.sp);
            chk("moving", e.inst, int'(mv[e.inst]), int'(e.mv));
            chk("hit_edge", e.inst, int'(he[e.inst]), int'(e.he));
         end
      end
   end

   logic [15:0] keys [6];

   initial begin : driver
      int len;
      logic [15:0] k;
      keys[0] = 16'h001A; keys[1] = 16'h0016; keys[2] = 16'h0004;
      keys[3] = 16'h0007; keys[4] = 16'h0000; keys[5] = 16'h0005;
      Reset = 1'b1;
      key   = 16'h0000;
      pause = 1'b0;
      for (int m = 0; m < 3; m++) model_reset(m);
      tick(16'h0000, 1'b0);
      tick(16'h0000, 1'b0);
      #2;
      Reset = 1'b0;
      for (int m = 0; m < 3; m++) chk("SizeOut", m, int'(sizeo[m]), 4);

      // Idle, then acceleration, reversal, coasting, pause and a mid-frame reset
      hold(16'h0000, 5);
      hold(16'h0007, 12);
      hold(16'h0004, 3);
      hold(16'h0000, 3);
      for (int i = 0; i < 3; i++) tick(16'h0007, 1'b1);
      hold(16'h0007, 4);
      mid_reset();

      // Drive into each edge of the playfield
      hold(16'h0007, 100);
      hold(16'h0000, 4);
      hold(16'h001A, 80);
      hold(16'h0004, 200);
      hold(16'h0016, 160);
      mid_reset();

      // Randomized key runs with occasional pause and reset
      for (int b = 0; b < 60; b++) begin
         k   = keys[$urandom_range(0, 5)];
         len = int'($urandom_range(1, 100));
         for (int j = 0; j < len; j++) tick(k, ($urandom_range(0, 19) == 0));
         if ($urandom_range(0, 9) == 0) mid_reset();
      end

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
